// File: rtl/activity_pkg.sv
// Shared constants for the activity profile generator and the high-activity
// tracker: thresholds, mode encodings, fixed rates, FSM states, hybrid table.
package activity_pkg;

    localparam int HIGH_RATE_DEF  = 64;
    localparam int HIGH_LIMIT_DEF = 60;
    localparam int SEG_COUNT_DEF  = 8;

    localparam logic [1:0] MODE_WALK   = 2'b00;
    localparam logic [1:0] MODE_JOG    = 2'b01;
    localparam logic [1:0] MODE_RUN    = 2'b10;
    localparam logic [1:0] MODE_HYBRID = 2'b11;

    localparam logic [7:0] RATE_WALK = 8'd32;
    localparam logic [7:0] RATE_JOG  = 8'd64;
    localparam logic [7:0] RATE_RUN  = 8'd128;

    // Ceiling for all 14-bit second counters.
    localparam logic [13:0] COUNT_MAX = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEADY = 2'd1,
        ST_HYBRID = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Hybrid schedule: steps/second and duration in seconds per segment.
    localparam logic [7:0] SEG_RATE [SEG_COUNT_DEF] =
        '{8'd20, 8'd33, 8'd66, 8'd27, 8'd70, 8'd30, 8'd19, 8'd124};
    localparam logic [6:0] SEG_LEN [SEG_COUNT_DEF] =
        '{7'd9, 7'd10, 7'd61, 7'd5, 7'd70, 7'd6, 7'd3, 7'd64};

    function automatic logic [13:0] sat_inc(input logic [13:0] a);
        return (a == COUNT_MAX) ? COUNT_MAX : a + 14'd1;
    endfunction

    function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [13:0] b);
        logic [14:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[14] ? COUNT_MAX : sum[13:0];
    endfunction

    function automatic logic [7:0] steady_rate(input logic [1:0] m);
        case (m)
            MODE_WALK: return RATE_WALK;
            MODE_JOG:  return RATE_JOG;
            default:   return RATE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/high_time_model.sv
// Golden model of the high-activity tracker: counts consecutive high seconds
// and credits time once the run reaches HIGH_LIMIT.
module high_time_model
    import activity_pkg::*;
#(
    parameter int HIGH_RATE  = HIGH_RATE_DEF,
    parameter int HIGH_LIMIT = HIGH_LIMIT_DEF
) (
    input  logic        secondclk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  rate,
    output logic [13:0] exp_high_time
);

    logic [13:0] run_q;
    logic [13:0] exp_q;

    assign exp_high_time = exp_q;

    // Retire one second: extend or break the run and credit high time.
    always_ff @(posedge secondclk) begin
        if (reset || clear) begin
            run_q <= '0;
            exp_q <= '0;
        end else if (enable) begin
            if (rate >= 8'(HIGH_RATE)) begin
                // NOTE: non-blocking update, so the comparisons below see the
                // run length before this second, not after it.
                run_q <= sat_inc(run_q);
                if (run_q == 14'(HIGH_LIMIT - 1))
                    exp_q <= sat_add(exp_q, 14'(HIGH_LIMIT));
                else if (run_q >= 14'(HIGH_LIMIT))
                    exp_q <= sat_inc(exp_q);
            end else begin
                run_q <= '0;
            end
        end
    end

endmodule

// File: rtl/activity_profile_gen.sv
// Scripted step-rate source: picks the step rate for each coming second in a
// fixed mode or along the hybrid schedule, and tracks expected high time.
module activity_profile_gen
    import activity_pkg::*;
#(
    parameter int HIGH_RATE  = HIGH_RATE_DEF,
    parameter int HIGH_LIMIT = HIGH_LIMIT_DEF,
    parameter int SEG_COUNT  = SEG_COUNT_DEF
) (
    input  logic        secondclk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    output logic [7:0]  rate,
    output logic        active,
    output logic        done,
    output logic [13:0] sec_index,
    output logic [2:0]  seg_index,
    output logic [13:0] exp_high_time
);

    localparam logic [2:0] LAST_SEG = 3'(SEG_COUNT - 1);

    state_t     state;
    logic [6:0] seg_sec;
    logic [2:0] next_seg;
    logic       model_clear;
    logic       model_enable;

    assign next_seg = seg_index + 3'd1;
    assign active   = (state == ST_STEADY) || (state == ST_HYBRID);
    assign done     = (state == ST_DONE);

    // A start (without stop) restarts the model; otherwise every active edge
    // retires the second described by the current rate.
    assign model_clear  = start && !stop;
    assign model_enable = active && !stop && !start;

    // Mode FSM, rate selection and second/segment bookkeeping.
    always_ff @(posedge secondclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rate      <= '0;
            sec_index <= '0;
            seg_index <= '0;
            seg_sec   <= '0;
        end else if (stop) begin
            state     <= ST_IDLE;
            rate      <= '0;
            seg_index <= '0;
            seg_sec   <= '0;
        end else if (start) begin
            sec_index <= '0;
            seg_index <= '0;
            seg_sec   <= '0;
            if (mode == MODE_HYBRID) begin
                state <= ST_HYBRID;
                rate  <= SEG_RATE[0];
            end else begin
                state <= ST_STEADY;
                rate  <= steady_rate(mode);
            end
        end else begin
            case (state)
                ST_STEADY: begin
                    sec_index <= sat_inc(sec_index);
                end
                ST_HYBRID: begin
                    sec_index <= sat_inc(sec_index);
                    if (seg_sec == SEG_LEN[seg_index] - 7'd1) begin
                        seg_sec <= '0;
                        if (seg_index == LAST_SEG) begin
                            state     <= ST_DONE;
                            rate      <= '0;
                            seg_index <= '0;
                        end else begin
                            seg_index <= next_seg;
                            rate      <= SEG_RATE[next_seg];
                        end
                    end else begin
                        seg_sec <= seg_sec + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    high_time_model #(
        .HIGH_RATE  (HIGH_RATE),
        .HIGH_LIMIT (HIGH_LIMIT)
    ) u_model (
        .secondclk     (secondclk),
        .reset         (reset),
        .clear         (model_clear),
        .enable        (model_enable),
        .rate          (rate),
        .exp_high_time (exp_high_time)
    );

endmodule

// File: tb/tb_activity_profile_gen.sv
// Directed bench for activity_profile_gen: steady modes, full hybrid run,
// stop/restart, reset mid-run, start+stop collision and saturation.
module tb_activity_profile_gen;

    logic        secondclk = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic [1:0]  mode      = 2'b00;
    logic [7:0]  rate;
    logic        active;
    logic        done;
    logic [13:0] sec_index;
    logic [2:0]  seg_index;
    logic [13:0] exp_high_time;

    int checks   = 0;
    int failures = 0;

    int seg_end  [7] = '{9, 19, 80, 85, 155, 161, 164};
    int seg_rate [8] = '{20, 33, 66, 27, 70, 30, 19, 124};

    activity_profile_gen dut (
        .secondclk     (secondclk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .rate          (rate),
        .active        (active),
        .done          (done),
        .sec_index     (sec_index),
        .seg_index     (seg_index),
        .exp_high_time (exp_high_time)
    );

    always #5 secondclk = ~secondclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge secondclk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rate"},   32'(rate), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_sec"},    32'(sec_index), 0);
        check({tag, "_seg"},    32'(seg_index), 0);
        check({tag, "_exp"},    32'(exp_high_time), 0);
    endtask

    initial begin
        int exp_seg;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check_idle_zero("reset");

        // Jog: rate 64 throughout, high time credited at edge 60
        pulse_start(2'b01);
        check("jog_e0_rate", 32'(rate), 64);
        check("jog_e0_active", 32'(active), 1);
        for (int k = 1; k <= 100; k++) begin
            step();
            check("jog_rate", 32'(rate), 64);
            if (k == 59)  check("jog_exp_e59", 32'(exp_high_time), 0);
            if (k == 60)  check("jog_exp_e60", 32'(exp_high_time), 60);
            if (k == 61)  check("jog_exp_e61", 32'(exp_high_time), 61);
        end
        check("jog_exp_e100", 32'(exp_high_time), 100);
        check("jog_sec_e100", 32'(sec_index), 100);

        // Walk via restart while active: model cleared, never high
        pulse_start(2'b00);
        check("walk_e0_exp", 32'(exp_high_time), 0);
        check("walk_e0_sec", 32'(sec_index), 0);
        for (int k = 1; k <= 200; k++) step();
        check("walk_rate", 32'(rate), 32);
        check("walk_exp", 32'(exp_high_time), 0);
        check("walk_sec", 32'(sec_index), 200);

        // Hybrid to completion; mode wiggles mid-run must be ignored
        pulse_start(2'b11);
        check("hyb_e0_rate", 32'(rate), 20);
        check("hyb_e0_seg", 32'(seg_index), 0);
        for (int k = 1; k < 228; k++) begin
            step();
            if (k == 40) mode = 2'b10;
            exp_seg = 0;
            for (int s = 0; s < 7; s++)
                if (k >= seg_end[s]) exp_seg = s + 1;
            check("hyb_seg", 32'(seg_index), 32'(exp_seg));
            check("hyb_rate", 32'(rate), 32'(seg_rate[exp_seg]));
            check("hyb_done_low", 32'(done), 0);
        end
        step();
        check("hyb_e228_done", 32'(done), 1);
        check("hyb_e228_active", 32'(active), 0);
        check("hyb_e228_rate", 32'(rate), 0);
        check("hyb_e228_exp", 32'(exp_high_time), 195);
        check("hyb_e228_sec", 32'(sec_index), 228);
        check("hyb_e228_seg", 32'(seg_index), 0);
        step();
        step();
        check("hyb_after_rate", 32'(rate), 0);
        check("hyb_after_done", 32'(done), 1);
        check("hyb_after_exp", 32'(exp_high_time), 195);

        // Stop from DONE: IDLE, counters held
        pulse_stop();
        check("stop_done_done", 32'(done), 0);
        check("stop_done_active", 32'(active), 0);
        check("stop_done_exp", 32'(exp_high_time), 195);
        check("stop_done_sec", 32'(sec_index), 228);

        // Run 50 s, stop, restart in jog: no carry-over of the run
        pulse_start(2'b10);
        check("run_e0_rate", 32'(rate), 128);
        for (int k = 1; k <= 50; k++) step();
        check("run50_exp", 32'(exp_high_time), 0);
        check("run50_sec", 32'(sec_index), 50);
        pulse_stop();
        check("run_stop_active", 32'(active), 0);
        check("run_stop_rate", 32'(rate), 0);
        pulse_start(2'b01);
        check("rejog_e0_exp", 32'(exp_high_time), 0);
        for (int k = 1; k <= 59; k++) step();
        check("rejog_e59_exp", 32'(exp_high_time), 0);
        step();
        check("rejog_e60_exp", 32'(exp_high_time), 60);

        // Reset at hybrid edge 100
        pulse_start(2'b11);
        for (int k = 1; k <= 100; k++) step();
        check("hyb100_seg", 32'(seg_index), 4);
        check("hyb100_rate", 32'(rate), 70);
        check("hyb100_exp", 32'(exp_high_time), 61);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_zero("midreset");

        // start and stop together: stop wins, from active and from IDLE
        pulse_start(2'b01);
        check("collide_pre_active", 32'(active), 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("collide_active", 32'(active), 0);
        check("collide_rate", 32'(rate), 0);
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("collide_idle_active", 32'(active), 0);
        check("collide_idle_rate", 32'(rate), 0);

        // Saturation of exp_high_time in run mode
        pulse_start(2'b10);
        for (int k = 1; k <= 70; k++) step();
        check("sat_pre_exp", 32'(exp_high_time), 70);
        force dut.u_model.exp_q = 14'h3FFF;
        step();
        release dut.u_model.exp_q;
        check("sat_e1_exp", 32'(exp_high_time), 16383);
        step();
        step();
        step();
        check("sat_e4_exp", 32'(exp_high_time), 16383);
        check("sat_rate", 32'(rate), 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
